// File: rtl/data_checker.sv
// AXI-Stream sink for the RDMA receive path: optional TREADY throttle, packet/cycle ID
// extraction, packet-ID sequence and length checking with saturating statistics.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_FIRST | waiting for the first beat of a packet (ID check happens here)
// S_BODY  | inside a packet, counting beats until TLAST
module data_checker #(
   parameter int DATA_WIDTH       = 512,
   parameter int CYCLE_ID_OFFSET  = 0,
   parameter int PACKET_ID_OFFSET = 64,
   parameter int BEATS_PER_PACKET = 64,
   parameter int STALL_PERIOD     = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  stall_enable,
   input  logic                  clear_counters,
   input  logic [DATA_WIDTH-1:0] AXIS_RX_TDATA,
   input  logic                  AXIS_RX_TVALID,
   input  logic                  AXIS_RX_TLAST,
   output logic                  AXIS_RX_TREADY,
   output logic [31:0]           packet_id,
   output logic [31:0]           cycle_id,
   output logic [31:0]           packet_count,
   output logic [31:0]           seq_errors,
   output logic [31:0]           len_errors,
   output logic                  error_flag,
   output logic [31:0]           first_err_pid
);

   localparam int SW = $clog2(STALL_PERIOD);
   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_PERIOD - 1);
   localparam logic [15:0]   BPP        = 16'(BEATS_PER_PACKET);

   typedef enum logic {S_FIRST, S_BODY} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] stall_ctr;
   logic [15:0]   beat_cnt, beats_now;
   logic [31:0]   expected_pid, pid_in, cid_in, err_pid;
   logic          have_prev, accept, seq_err, len_err, pkt_done;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign pid_in         = AXIS_RX_TDATA[PACKET_ID_OFFSET +: 32];
   assign cid_in         = AXIS_RX_TDATA[CYCLE_ID_OFFSET +: 32];
   assign AXIS_RX_TREADY = resetn && !(stall_enable && (stall_ctr == STALL_LAST));
   assign accept         = AXIS_RX_TVALID && AXIS_RX_TREADY;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_FIRST;
         stall_ctr <= '0;
      end else begin
         state     <= state_nxt;
         stall_ctr <= (stall_ctr == STALL_LAST) ? '0 : stall_ctr + SW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      beats_now = beat_cnt;
      seq_err   = 1'b0;
      len_err   = 1'b0;
      pkt_done  = 1'b0;
      err_pid   = packet_id;
      if (accept) begin
         case (state)
            S_FIRST: begin
               seq_err   = have_prev && (pid_in != expected_pid);
               err_pid   = pid_in;
               beats_now = 16'd1;
               if (!AXIS_RX_TLAST) state_nxt = S_BODY;
            end
            S_BODY: begin
               beats_now = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
               if (AXIS_RX_TLAST) state_nxt = S_FIRST;
            end
            default: state_nxt = S_FIRST;
         endcase
         pkt_done = AXIS_RX_TLAST;
         len_err  = AXIS_RX_TLAST && (beats_now != BPP);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         beat_cnt      <= '0;
         expected_pid  <= '0;
         have_prev     <= 1'b0;
         packet_id     <= '0;
         cycle_id      <= '0;
         packet_count  <= '0;
         seq_errors    <= '0;
         len_errors    <= '0;
         error_flag    <= 1'b0;
         first_err_pid <= '0;
      end else begin
         if (accept) begin
            cycle_id <= cid_in;
            beat_cnt <= beats_now;
            if (state == S_FIRST) begin
               packet_id    <= pid_in;
               expected_pid <= pid_in + 32'd1;
               have_prev    <= 1'b1;
            end
         end
         // Clear takes priority: an event landing in the clear cycle is dropped.
         if (clear_counters) begin
            packet_count  <= '0;
            seq_errors    <= '0;
            len_errors    <= '0;
            error_flag    <= 1'b0;
            first_err_pid <= '0;
         end else begin
            if (pkt_done) packet_count <= sat_inc(packet_count);
            if (seq_err)  seq_errors   <= sat_inc(seq_errors);
            if (len_err)  len_errors   <= sat_inc(len_errors);
            if ((seq_err || len_err) && !error_flag) begin
               error_flag    <= 1'b1;
               first_err_pid <= err_pid;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_checker.sv
// Directed bench for data_checker with BEATS_PER_PACKET=4, STALL_PERIOD=4 and a
// 128-bit stream; expected values are hand-computed per scenario.
module tb_data_checker;

   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          stall_enable = 1'b0;
   logic          clear_counters = 1'b0;
   logic [DW-1:0] tdata = '0;
   logic          tvalid = 1'b0;
   logic          tlast = 1'b0;
   logic          tready;
   logic [31:0]   packet_id, cycle_id, packet_count, seq_errors, len_errors, first_err_pid;
   logic          error_flag;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   data_checker #(
      .DATA_WIDTH(DW), .CYCLE_ID_OFFSET(0), .PACKET_ID_OFFSET(64),
      .BEATS_PER_PACKET(4), .STALL_PERIOD(4)
   ) dut (
      .clk(clk), .resetn(resetn), .stall_enable(stall_enable),
      .clear_counters(clear_counters), .AXIS_RX_TDATA(tdata),
      .AXIS_RX_TVALID(tvalid), .AXIS_RX_TLAST(tlast), .AXIS_RX_TREADY(tready),
      .packet_id(packet_id), .cycle_id(cycle_id), .packet_count(packet_count),
      .seq_errors(seq_errors), .len_errors(len_errors), .error_flag(error_flag),
      .first_err_pid(first_err_pid)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   int not_ready_seen = 0;

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic send_beat(input logic [31:0] pid, input logic [31:0] cid,
                            input logic last, input logic clr);
      int n = 0;
      tdata          = '0;
      tdata[64 +: 32] = pid;
      tdata[0 +: 32]  = cid;
      tvalid         = 1'b1;
      tlast          = last;
      clear_counters = clr;
      while (!tready && n < 20) begin
         not_ready_seen++;
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_eq("accept_timeout", 32'(tready), 32'd1);
      @(negedge clk);
      tvalid         = 1'b0;
      tlast          = 1'b0;
      clear_counters = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] pid, input int nbeats,
                           input logic [31:0] cid0, input logic clr_last);
      for (int b = 0; b < nbeats; b++)
         send_beat(pid, cid0 + 32'(b), b == nbeats - 1, clr_last && (b == nbeats - 1));
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_clear();
      clear_counters = 1'b1;
      @(negedge clk);
      clear_counters = 1'b0;
   endtask

   initial begin
      int lows, acc;
      logic [31:0] last_cid;
      logic        took;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_tready", 32'(tready), 32'd0);
      check_eq("rst_packet_count", packet_count, 32'd0);
      check_eq("rst_error_flag", 32'(error_flag), 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Clean sequence 10,11,12 with cycle IDs 0..11
      send_pkt(32'd10, 4, 32'd0, 1'b0);
      check_eq("t1_pid_after_first", packet_id, 32'd10);
      send_pkt(32'd11, 4, 32'd4, 1'b0);
      send_pkt(32'd12, 4, 32'd8, 1'b0);
      check_eq("t1_packet_count", packet_count, 32'd3);
      check_eq("t1_seq_errors", seq_errors, 32'd0);
      check_eq("t1_len_errors", len_errors, 32'd0);
      check_eq("t1_packet_id", packet_id, 32'd12);
      check_eq("t1_cycle_id", cycle_id, 32'd11);
      check_eq("t1_tready_stalls", 32'(not_ready_seen), 32'd0);

      // Sequence gap 5,6,9,10 from a fresh reset
      pulse_reset();
      check_eq("t2_reset_pid", packet_id, 32'd0);
      send_pkt(32'd5, 4, 32'd100, 1'b0);
      send_pkt(32'd6, 4, 32'd104, 1'b0);
      send_pkt(32'd9, 4, 32'd108, 1'b0);
      send_pkt(32'd10, 4, 32'd112, 1'b0);
      check_eq("t2_seq_errors", seq_errors, 32'd1);
      check_eq("t2_error_flag", 32'(error_flag), 32'd1);
      check_eq("t2_first_err_pid", first_err_pid, 32'd9);
      check_eq("t2_packet_count", packet_count, 32'd4);

      // Length errors, then clear coinciding with a TLAST
      pulse_clear();
      check_eq("t3_cleared_count", packet_count, 32'd0);
      check_eq("t3_cleared_flag", 32'(error_flag), 32'd0);
      send_pkt(32'd11, 3, 32'd200, 1'b0);
      send_pkt(32'd12, 5, 32'd203, 1'b0);
      check_eq("t3_len_errors", len_errors, 32'd2);
      check_eq("t3_packet_count", packet_count, 32'd2);
      check_eq("t3_seq_errors", seq_errors, 32'd0);
      check_eq("t3_first_err_pid", first_err_pid, 32'd11);
      send_pkt(32'd13, 4, 32'd208, 1'b1);
      check_eq("t3_clr_packet_count", packet_count, 32'd0);
      check_eq("t3_clr_len_errors", len_errors, 32'd0);
      check_eq("t3_clr_error_flag", 32'(error_flag), 32'd0);
      check_eq("t3_clr_first_err", first_err_pid, 32'd0);
      check_eq("t3_pid_kept", packet_id, 32'd13);
      check_eq("t3_cid_kept", cycle_id, 32'd211);

      // Throttled stream, TVALID held for 40 cycles
      stall_enable = 1'b1;
      lows = 0;
      acc  = 0;
      last_cid = '0;
      for (int i = 0; i < 40; i++) begin
         tdata           = '0;
         tdata[64 +: 32] = 32'd14 + 32'(acc / 4);
         tdata[0 +: 32]  = 32'd1000 + 32'(acc);
         tvalid          = 1'b1;
         tlast           = (acc % 4) == 3;
         took            = tready;
         if (took) begin
            last_cid = 32'd1000 + 32'(acc);
            acc++;
         end else begin
            lows++;
         end
         @(negedge clk);
         if (took) check_eq("t4_cycle_id", cycle_id, last_cid);
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
      stall_enable = 1'b0;
      check_eq("t4_ready_lows", 32'(lows), 32'd10);
      check_eq("t4_accepted", 32'(acc), 32'd30);
      check_eq("t4_packet_count", packet_count, 32'd7);
      check_eq("t4_seq_errors", seq_errors, 32'd0);
      check_eq("t4_len_errors", len_errors, 32'd0);
      check_eq("t4_packet_id", packet_id, 32'd21);

      // Reset in the middle of pid 20, then pid 50
      pulse_reset();
      send_beat(32'd20, 32'd300, 1'b0, 1'b0);
      send_beat(32'd20, 32'd301, 1'b0, 1'b0);
      check_eq("t5_pre_rst_pid", packet_id, 32'd20);
      resetn = 1'b0;
      #1;
      check_eq("t5_rst_tready", 32'(tready), 32'd0);
      check_eq("t5_rst_packet_id", packet_id, 32'd0);
      check_eq("t5_rst_cycle_id", cycle_id, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      send_pkt(32'd50, 4, 32'd400, 1'b0);
      check_eq("t5_seq_errors", seq_errors, 32'd0);
      check_eq("t5_packet_count", packet_count, 32'd1);
      check_eq("t5_len_errors", len_errors, 32'd0);
      check_eq("t5_packet_id", packet_id, 32'd50);

      // Saturation and 32-bit ID wrap
      force dut.seq_errors = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.seq_errors;
      send_pkt(32'd60, 4, 32'd500, 1'b0);
      check_eq("t6_seq_saturated", seq_errors, 32'hFFFF_FFFF);
      check_eq("t6_first_err_pid", first_err_pid, 32'd60);
      pulse_clear();
      send_pkt(32'hFFFF_FFFF, 4, 32'd600, 1'b0);
      check_eq("t6_seq_after_gap", seq_errors, 32'd1);
      send_pkt(32'd0, 4, 32'd604, 1'b0);
      check_eq("t6_seq_after_wrap", seq_errors, 32'd1);
      check_eq("t6_packet_count", packet_count, 32'd2);
      check_eq("t6_first_err_wrap", first_err_pid, 32'hFFFF_FFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
